// File: rtl/hzrd_pkg.sv
// Shared types and defaults for the hazard/forwarding scoreboard.
// The slot record is sized for the widest supported register file.
package hzrd_pkg;

  localparam int NREG_DFLT       = 32;
  localparam int FWD_STAGES_DFLT = 2;
  localparam int AW_MAX          = 8;

  typedef struct packed {
    logic              wen;
    logic [AW_MAX-1:0] waddr;
    logic              is_load;
  } slot_t;

endpackage

// File: rtl/hzrd_match.sv
// Youngest-match priority encoder over the in-flight write slots.
// Returns a one-hot bypass select, or a load-not-ready flag instead.
module hzrd_match
  import hzrd_pkg::*;
#(
  parameter int NS = FWD_STAGES_DFLT,
  parameter int LL = 1,
  parameter int AW = 5
) (
  input  slot_t [NS-1:0] slots_i,
  input  logic  [AW-1:0] rs_i,
  output logic  [NS-1:0] sel_o,
  output logic           ld_nr_o
);

  logic [AW_MAX-1:0] rs_x;

  assign rs_x = AW_MAX'(rs_i);

  always_comb begin
    logic found;
    found   = 1'b0;
    sel_o   = '0;
    ld_nr_o = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (!found && (rs_i != '0) &&
          slots_i[k].wen &&
          (slots_i[k].waddr == rs_x)) begin
        found = 1'b1;
        if (slots_i[k].is_load && (k < LL))
          ld_nr_o = 1'b1;
        else
          sel_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hzrd_sb.sv
// Hazard detection / forwarding unit with a one-entry
// multi-cycle scoreboard, flush squash and WAW protection.
module hzrd_sb
  import hzrd_pkg::*;
#(
  parameter int NREG       = NREG_DFLT,
  parameter int FWD_STAGES = FWD_STAGES_DFLT,
  parameter int LOAD_LAT   = 1,
  localparam int AW        = $clog2(NREG)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  input  logic                  i_rd_wen,
  input  logic [AW-1:0]         i_rd_waddr,
  input  logic [AW-1:0]         i_rs1_raddr,
  input  logic [AW-1:0]         i_rs2_raddr,
  input  logic                  i_is_load,
  input  logic                  i_is_mc,
  input  logic                  i_mc_done,
  input  logic [AW-1:0]         i_mc_waddr,
  input  logic                  i_flush,
  output logic                  o_if_id_halt,
  output logic                  o_id_ex_halt,
  output logic [FWD_STAGES-1:0] o_fwd_op1,
  output logic [FWD_STAGES-1:0] o_fwd_op2,
  output logic                  o_fwd_mc_op1,
  output logic                  o_fwd_mc_op2,
  output logic                  o_mc_pending
);

  slot_t [FWD_STAGES-1:0] slot_q, slot_d;
  logic                   mc_busy_q, mc_busy_d;
  logic [AW-1:0]          mc_rd_q, mc_rd_d;

  logic [FWD_STAGES-1:0] sel1, sel2;
  logic ldnr1, ldnr2;
  logic mc_hit1, mc_hit2, mc_byp;
  logic mc_fwd1, mc_fwd2;
  logic lu1, lu2, raw1, raw2;
  logic waw, strc, stall;
  logic accept, mc_issue;

  hzrd_match #(
    .NS(FWD_STAGES), .LL(LOAD_LAT), .AW(AW)
  ) u_m1 (
    .slots_i (slot_q),
    .rs_i    (i_rs1_raddr),
    .sel_o   (sel1),
    .ld_nr_o (ldnr1)
  );

  hzrd_match #(
    .NS(FWD_STAGES), .LL(LOAD_LAT), .AW(AW)
  ) u_m2 (
    .slots_i (slot_q),
    .rs_i    (i_rs2_raddr),
    .sel_o   (sel2),
    .ld_nr_o (ldnr2)
  );

  always_comb begin
    mc_hit1 = mc_busy_q && (i_rs1_raddr != '0) &&
              (i_rs1_raddr == mc_rd_q);
    mc_hit2 = mc_busy_q && (i_rs2_raddr != '0) &&
              (i_rs2_raddr == mc_rd_q);
    mc_byp  = i_mc_done && (i_mc_waddr == mc_rd_q);
    mc_fwd1 = mc_hit1 && mc_byp;
    mc_fwd2 = mc_hit2 && mc_byp;
    raw1    = mc_hit1 && !mc_byp;
    raw2    = mc_hit2 && !mc_byp;
    // a completing MC result is younger than any slot
    lu1     = ldnr1 && !mc_fwd1;
    lu2     = ldnr2 && !mc_fwd2;
    waw     = i_rd_wen && (i_rd_waddr != '0) && mc_busy_q &&
              (i_rd_waddr == mc_rd_q) && !i_mc_done;
    strc    = i_is_mc && mc_busy_q && !i_mc_done;
    stall   = i_id_valid && !i_flush &&
              (lu1 || lu2 || raw1 || raw2 || waw || strc);
    accept  = i_id_valid && !stall && !i_flush;
    mc_issue = accept && i_is_mc && (i_rd_waddr != '0);
  end

  always_comb begin
    slot_d = '0;
    for (int k = 1; k < FWD_STAGES; k++)
      slot_d[k] = slot_q[k-1];
    if (accept && !i_is_mc) begin
      slot_d[0].wen     = i_rd_wen;
      slot_d[0].waddr   = AW_MAX'(i_rd_waddr);
      slot_d[0].is_load = i_is_load;
    end
    mc_busy_d = mc_busy_q;
    mc_rd_d   = mc_rd_q;
    if (mc_issue) begin
      mc_busy_d = 1'b1;
      mc_rd_d   = i_rd_waddr;
    end else if (i_mc_done) begin
      mc_busy_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      slot_q    <= '0;
      mc_busy_q <= 1'b0;
      mc_rd_q   <= '0;
    end else begin
      slot_q    <= slot_d;
      mc_busy_q <= mc_busy_d;
      mc_rd_q   <= mc_rd_d;
    end
  end

  always_comb begin
    o_if_id_halt = 1'b0;
    o_id_ex_halt = 1'b0;
    o_fwd_op1    = '0;
    o_fwd_op2    = '0;
    o_fwd_mc_op1 = 1'b0;
    o_fwd_mc_op2 = 1'b0;
    o_mc_pending = 1'b0;
    if (i_rst) begin
      o_if_id_halt = stall;
      o_id_ex_halt = stall;
      o_fwd_op1    = mc_fwd1 ? '0 : sel1;
      o_fwd_op2    = mc_fwd2 ? '0 : sel2;
      o_fwd_mc_op1 = mc_fwd1;
      o_fwd_mc_op2 = mc_fwd2;
      o_mc_pending = mc_busy_q;
    end
  end

endmodule

// File: tb/tb_hzrd_sb.sv
// Randomised + directed bench for hzrd_sb, two configurations
// (2 slots/lat 1 and 3 slots/lat 2) against a history-based model.
module tb_hzrd_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid, wen, ld, mc, done, flush;
  logic [4:0] rd, rs1, rs2, dw;

  logic       a_ifh, a_exh, a_m1, a_m2, a_pd;
  logic [1:0] a_f1, a_f2;
  logic       b_ifh, b_exh, b_m1, b_m2, b_pd;
  logic [2:0] b_f1, b_f2;

  hzrd_sb #(.NREG(32), .FWD_STAGES(2), .LOAD_LAT(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_id_valid(valid),
    .i_rd_wen(wen), .i_rd_waddr(rd),
    .i_rs1_raddr(rs1), .i_rs2_raddr(rs2),
    .i_is_load(ld), .i_is_mc(mc),
    .i_mc_done(done), .i_mc_waddr(dw), .i_flush(flush),
    .o_if_id_halt(a_ifh), .o_id_ex_halt(a_exh),
    .o_fwd_op1(a_f1), .o_fwd_op2(a_f2),
    .o_fwd_mc_op1(a_m1), .o_fwd_mc_op2(a_m2),
    .o_mc_pending(a_pd)
  );

  hzrd_sb #(.NREG(32), .FWD_STAGES(3), .LOAD_LAT(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_id_valid(valid),
    .i_rd_wen(wen), .i_rd_waddr(rd),
    .i_rs1_raddr(rs1), .i_rs2_raddr(rs2),
    .i_is_load(ld), .i_is_mc(mc),
    .i_mc_done(done), .i_mc_waddr(dw), .i_flush(flush),
    .o_if_id_halt(b_ifh), .o_id_ex_halt(b_exh),
    .o_fwd_op1(b_f1), .o_fwd_op2(b_f2),
    .o_fwd_mc_op1(b_m1), .o_fwd_mc_op2(b_m2),
    .o_mc_pending(b_pd)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s t=%0t got=%0h exp=%0h",
                 tag, $time, got, exp);
    end
  endtask

  // model: history of writes that entered the pipe, age 0 = EX
  int         fs [2] = '{2, 3};
  int         ll [2] = '{1, 2};
  logic       hw [2][4];
  logic [4:0] ha [2][4];
  logic       hl [2][4];
  logic       mb [2];
  logic [4:0] mr [2];
  logic       est[2];

  task automatic op_eval(input int i, input logic [4:0] rs,
                         output logic [3:0] f,
                         output logic mf, output logic st);
    f = '0; mf = 1'b0; st = 1'b0;
    if (rs == 5'd0) return;
    if (mb[i] && rs == mr[i]) begin
      if (done && dw == mr[i]) begin
        mf = 1'b1;
        return;
      end
      st = 1'b1;
    end
    for (int k = 0; k < fs[i]; k++) begin
      if (hw[i][k] && ha[i][k] == rs) begin
        if (hl[i][k] && k < ll[i]) st = 1'b1;
        else f[k] = 1'b1;
        return;
      end
    end
  endtask

  task automatic sample();
    logic [3:0] f1, f2, g1, g2;
    logic m1, m2, s1, s2, st, hz, pd, gm1, gm2, gh, ge, gp;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      op_eval(i, rs1, f1, m1, s1);
      op_eval(i, rs2, f2, m2, s2);
      hz = (wen && rd != 0 && mb[i] && rd == mr[i] && !done) ||
           (mc && mb[i] && !done);
      st = valid && !flush && (s1 || s2 || hz);
      pd = mb[i];
      est[i] = st;
      if (!rst) begin
        f1 = '0; f2 = '0; m1 = 0; m2 = 0; st = 0; pd = 0;
      end
      if (i == 0) begin
        gh = a_ifh; ge = a_exh; g1 = {2'b0, a_f1}; g2 = {2'b0, a_f2};
        gm1 = a_m1; gm2 = a_m2; gp = a_pd;
      end else begin
        gh = b_ifh; ge = b_exh; g1 = {1'b0, b_f1}; g2 = {1'b0, b_f2};
        gm1 = b_m1; gm2 = b_m2; gp = b_pd;
      end
      chk($sformatf("if_id_halt[%0d]", i), 32'(gh), 32'(st));
      chk($sformatf("id_ex_halt[%0d]", i), 32'(ge), 32'(st));
      chk($sformatf("fwd_op1[%0d]", i), 32'(g1), 32'(f1));
      chk($sformatf("fwd_op2[%0d]", i), 32'(g2), 32'(f2));
      chk($sformatf("fwd_mc1[%0d]", i), 32'(gm1), 32'(m1));
      chk($sformatf("fwd_mc2[%0d]", i), 32'(gm2), 32'(m2));
      chk($sformatf("mc_pend[%0d]", i), 32'(gp), 32'(pd));
    end
  endtask

  task automatic adv();
    logic acc;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        for (int k = 0; k < 4; k++) begin
          hw[i][k] = 0; ha[i][k] = 0; hl[i][k] = 0;
        end
        mb[i] = 0; mr[i] = 0;
      end else begin
        acc = valid && !flush && !est[i];
        for (int k = 3; k > 0; k--) begin
          hw[i][k] = hw[i][k-1];
          ha[i][k] = ha[i][k-1];
          hl[i][k] = hl[i][k-1];
        end
        hw[i][0] = acc && !mc && wen;
        ha[i][0] = rd;
        hl[i][0] = ld;
        if (acc && mc && rd != 0) begin
          mb[i] = 1; mr[i] = rd;
        end else if (done) begin
          mb[i] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic drv(input logic v, input logic w, input int d,
                     input int s1, input int s2, input logic l,
                     input logic m, input logic dn, input int dwv,
                     input logic f);
    valid = v; wen = w; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
    ld = l; mc = m; done = dn; dw = 5'(dwv); flush = f;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        hw[i][k] = 0; ha[i][k] = 0; hl[i][k] = 0;
      end
      mb[i] = 0; mr[i] = 0; est[i] = 0;
    end
    rst = 0;
    idle();
    #1;
    cyc(); cyc();
    rst = 1;
    cyc();

    // add x5 ; add x6,x5,x5
    drv(1, 1, 5, 1, 2, 0, 0, 0, 0, 0); cyc();
    drv(1, 1, 6, 5, 5, 0, 0, 0, 0, 0); sample();
    chk("tp_add_f1", 32'(a_f1), 32'h1);
    chk("tp_add_f2", 32'(a_f2), 32'h1);
    chk("tp_add_halt", 32'(a_ifh), 32'h0);
    adv();

    // lw x7 ; sub x8,x7,x0
    drv(1, 1, 7, 0, 0, 1, 0, 0, 0, 0); cyc();
    drv(1, 1, 8, 7, 0, 0, 0, 0, 0, 0); sample();
    chk("tp_lu_halt", 32'(a_ifh), 32'h1);
    chk("tp_lu_f1z", 32'(a_f1), 32'h0);
    adv();
    sample();
    chk("tp_lu_f1", 32'(a_f1), 32'h2);
    chk("tp_lu_f2", 32'(a_f2), 32'h0);
    chk("tp_lu_nohalt", 32'(a_exh), 32'h0);
    chk("tp_lu2_halt", 32'(b_exh), 32'h1);
    adv();
    sample();
    chk("tp_lu2_f1", 32'(b_f1), 32'h4);
    chk("tp_lu2_nohalt", 32'(b_ifh), 32'h0);
    adv();

    // mul x9 ; add x10,x9,x1 waits for completion
    drv(1, 1, 9, 0, 0, 0, 1, 0, 0, 0); cyc();
    drv(1, 1, 10, 9, 1, 0, 0, 0, 0, 0); sample();
    chk("tp_mc_halt", 32'(a_ifh), 32'h1);
    chk("tp_mc_pend", 32'(a_pd), 32'h1);
    adv();
    cyc();
    done = 1; dw = 5'd9; sample();
    chk("tp_mc_fwd", 32'(a_m1), 32'h1);
    chk("tp_mc_nohalt", 32'(a_ifh), 32'h0);
    adv();
    idle(); sample();
    chk("tp_mc_fall", 32'(a_pd), 32'h0);
    adv();

    // WAW, structural, issue on completion
    drv(1, 1, 9, 0, 0, 0, 1, 0, 0, 0); cyc();
    drv(1, 1, 9, 1, 0, 0, 0, 0, 0, 0); sample();
    chk("tp_waw", 32'(a_ifh), 32'h1);
    adv();
    drv(1, 1, 11, 0, 0, 0, 1, 0, 0, 0); sample();
    chk("tp_struct", 32'(a_ifh), 32'h1);
    adv();
    done = 1; dw = 5'd9; sample();
    chk("tp_reissue", 32'(a_ifh), 32'h0);
    adv();
    idle(); sample();
    chk("tp_reissue_pend", 32'(a_pd), 32'h1);
    adv();
    done = 1; dw = 5'd11; cyc();

    // flush beats a load-use stall
    drv(1, 1, 3, 0, 0, 1, 0, 0, 0, 0); cyc();
    drv(1, 1, 4, 3, 0, 0, 0, 0, 0, 1); sample();
    chk("tp_flush_a", 32'(a_ifh), 32'h0);
    chk("tp_flush_b", 32'(b_exh), 32'h0);
    adv();
    drv(1, 1, 4, 3, 4, 0, 0, 0, 0, 0); sample();
    chk("tp_flush_bubble", 32'(a_f2), 32'h0);
    chk("tp_flush_lw", 32'(a_f1), 32'h2);
    adv();
    idle(); cyc(); cyc();

    // reset in the middle of a multi-cycle op
    drv(1, 1, 12, 0, 0, 0, 1, 0, 0, 0); cyc();
    drv(1, 1, 13, 12, 0, 0, 0, 0, 0, 0); rst = 0; sample();
    chk("tp_rst_halt", 32'(a_ifh), 32'h0);
    chk("tp_rst_pend", 32'(b_pd), 32'h0);
    adv();
    rst = 1; idle(); sample();
    chk("tp_rst_after", 32'(a_pd), 32'h0);
    adv();

    for (int n = 0; n < 3000; n++) begin
      valid = ($urandom % 8) != 0;
      wen   = ($urandom % 4) != 0;
      rd    = 5'($urandom % 8);
      rs1   = 5'($urandom % 8);
      rs2   = 5'($urandom % 8);
      ld    = ($urandom % 4) == 0;
      mc    = ($urandom % 6) == 0;
      flush = ($urandom % 16) == 0;
      done  = 0;
      dw    = 5'($urandom % 8);
      if (mb[0] && ($urandom % 4) == 0) begin
        done = 1; dw = mr[0];
      end else if (($urandom % 40) == 0) begin
        done = 1;
      end
      rst = ($urandom % 300) != 0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
